// File: rtl/demux_4_pkg.sv
// Shared routing constants for the 4-way result mux/demux pair.
// Select codes map A..D to 0..3; sel_onehot turns a select into a per-channel load mask.
package demux_4_pkg;
  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
    logic [3:0] oh;
    oh = 4'b0000;
    case (sel)
      SEL_A:   oh = 4'b0001;
      SEL_B:   oh = 4'b0010;
      SEL_C:   oh = 4'b0100;
      SEL_D:   oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction
endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register with valid/ready handshake and accept counter.
// A load wins over a drain, so the same-cycle case streams without a bubble.
module demux_slot #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      count <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= data_in;
      count <= count + 1'b1;
    end else if (valid && ready) begin
      // Drained and not refilled: data is kept, only valid drops.
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_4.sv
// Registered 1-to-4 distributor: routes each accepted word to one of four
// independently handshaked holding slots chosen by select.
module demux_4
  import demux_4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [CNT_W-1:0] count_A,
  output logic [CNT_W-1:0] count_B,
  output logic [CNT_W-1:0] count_C,
  output logic [CNT_W-1:0] count_D
);

  logic             acc;
  logic [3:0]       load;
  logic [WIDTH-1:0] ch_data  [4];
  logic [CNT_W-1:0] ch_count [4];

  // Only the addressed slot gates acceptance; other channels may stall freely.
  assign in_ready = !out_valid[select] || out_ready[select];
  assign acc      = in_valid && in_ready;
  assign load     = acc ? sel_onehot(select) : 4'b0000;

  for (genvar k = 0; k < 4; k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .load   (load[k]),
      .data_in(in_data),
      .ready  (out_ready[k]),
      .valid  (out_valid[k]),
      .data   (ch_data[k]),
      .count  (ch_count[k])
    );
  end

  assign A       = ch_data[0];
  assign B       = ch_data[1];
  assign C       = ch_data[2];
  assign D       = ch_data[3];
  assign count_A = ch_count[0];
  assign count_B = ch_count[1];
  assign count_C = ch_count[2];
  assign count_D = ch_count[3];

endmodule

// File: tb/tb_demux_4.sv
// Directed bench for demux_4: table-driven routing/handshake vectors plus
// hand-written reset, streaming, counter-wrap and mid-stream reset sequences.
module tb_demux_4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  select;
  logic [31:0] A, B, C, D;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] count_A, count_B, count_C, count_D;

  logic        s_in_ready;
  logic [31:0] s_A, s_B, s_C, s_D;
  logic [3:0]  s_out_valid;
  logic [3:0]  s_count_A, s_count_B, s_count_C, s_count_D;

  int checks = 0;
  int errors = 0;

  demux_4 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .select(select), .A(A), .B(B), .C(C), .D(D),
    .out_valid(out_valid), .out_ready(out_ready),
    .count_A(count_A), .count_B(count_B), .count_C(count_C), .count_D(count_D)
  );

  demux_4 #(.WIDTH(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .select(select), .A(s_A), .B(s_B), .C(s_C), .D(s_D),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .count_A(s_count_A), .count_B(s_count_B), .count_C(s_count_C), .count_D(s_count_D)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, " out_valid"}, {60'd0, out_valid}, 64'h0);
    chk({tag, " A"}, {32'd0, A}, 64'h0);
    chk({tag, " B"}, {32'd0, B}, 64'h0);
    chk({tag, " C"}, {32'd0, C}, 64'h0);
    chk({tag, " D"}, {32'd0, D}, 64'h0);
    chk({tag, " counts"}, {count_A, count_B, count_C, count_D}, 64'h0);
    chk({tag, " small counts"}, {48'd0, s_count_A, s_count_B, s_count_C, s_count_D}, 64'h0);
  endtask

  // Producer must hold a stalled word steady until it is accepted.
  logic        p_stall = 1'b0;
  logic [1:0]  p_sel;
  logic [31:0] p_data;
  always @(posedge clk) begin
    if (!rst && p_stall) begin
      checks++;
      if (!in_valid || select !== p_sel || in_data !== p_data) begin
        errors++;
        $display("FAIL protocol_hold: got v=%0b sel=%0d d=%0h expected v=1 sel=%0d d=%0h",
                 in_valid, select, in_data, p_sel, p_data);
      end
    end
    p_stall <= !rst && in_valid && !in_ready;
    p_sel   <= select;
    p_data  <= in_data;
  end

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic [31:0] d;
    logic [3:0]  ordy;
    logic        eird;
    logic [3:0]  eov;
    logic [31:0] ea, eb, ec, ed;
    logic [15:0] ca, cb, cc, cd;
  } vec_t;

  vec_t tbl [6];

  initial begin
    // iv sel data ordy | in_ready out_valid A B C D | counts A..D after edge
    tbl[0] = '{1'b1, 2'd2, 32'hDEADBEEF, 4'b0000, 1'b1, 4'b0100,
               32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 16'd0, 16'd0, 16'd1, 16'd0};
    tbl[1] = '{1'b0, 2'd2, 32'h0, 4'b0000, 1'b0, 4'b0100,
               32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 16'd0, 16'd0, 16'd1, 16'd0};
    tbl[2] = '{1'b1, 2'd0, 32'h1, 4'b0000, 1'b1, 4'b0101,
               32'h1, 32'h0, 32'hDEADBEEF, 32'h0, 16'd1, 16'd0, 16'd1, 16'd0};
    tbl[3] = '{1'b0, 2'd0, 32'h0, 4'b0001, 1'b1, 4'b0100,
               32'h1, 32'h0, 32'hDEADBEEF, 32'h0, 16'd1, 16'd0, 16'd1, 16'd0};
    tbl[4] = '{1'b1, 2'd2, 32'h0000CAFE, 4'b0100, 1'b1, 4'b0100,
               32'h1, 32'h0, 32'h0000CAFE, 32'h0, 16'd1, 16'd0, 16'd2, 16'd0};
    tbl[5] = '{1'b1, 2'd1, 32'h00000055, 4'b0100, 1'b1, 4'b0010,
               32'h1, 32'h55, 32'h0000CAFE, 32'h0, 16'd1, 16'd1, 16'd2, 16'd0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; select = '0; out_ready = '0;
    step();
    step();
    chk_all_reset("por");
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      in_valid = tbl[i].iv; select = tbl[i].sel;
      in_data = tbl[i].d; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d in_ready", i), {63'd0, in_ready}, {63'd0, tbl[i].eird});
      step();
      chk($sformatf("vec%0d out_valid", i), {60'd0, out_valid}, {60'd0, tbl[i].eov});
      chk($sformatf("vec%0d data AB", i), {A, B}, {tbl[i].ea, tbl[i].eb});
      chk($sformatf("vec%0d data CD", i), {C, D}, {tbl[i].ec, tbl[i].ed});
      chk($sformatf("vec%0d counts", i), {count_A, count_B, count_C, count_D},
          {tbl[i].ca, tbl[i].cb, tbl[i].cc, tbl[i].cd});
    end

    // Async reset with out_valid=0101 held: clears before the next edge.
    in_valid = 1'b0; out_ready = 4'b1111;
    step();
    out_ready = 4'b0000; in_valid = 1'b1; select = 2'd0; in_data = 32'h11;
    step();
    select = 2'd2; in_data = 32'h22;
    step();
    in_valid = 1'b0;
    chk("pre_reset out_valid", {60'd0, out_valid}, 64'h5);
    #2 rst = 1'b1;
    #1;
    chk_all_reset("async_rst");
    #1 rst = 1'b0;
    step();

    // Streaming 1..8 into D with every consumer ready.
    out_ready = 4'b1111; select = 2'd3; in_valid = 1'b1;
    for (int w = 1; w <= 8; w++) begin
      in_data = w;
      #1;
      chk($sformatf("stream%0d in_ready", w), {63'd0, in_ready}, 64'h1);
      step();
      chk($sformatf("stream%0d D", w), {32'd0, D}, w);
      chk($sformatf("stream%0d vld/cnt", w), {47'd0, out_valid[3], count_D}, {47'd0, 1'b1, 16'(w)});
    end
    in_valid = 1'b0;
    step();
    chk("stream drain", {59'd0, out_valid[3], D}, {31'd0, 1'b0, 32'd8});

    // Counter wrap: 17 accepts to B; 4-bit instance reads 1.
    select = 2'd1; in_valid = 1'b1;
    for (int w = 0; w < 17; w++) begin
      in_data = 32'h100 + w;
      step();
    end
    in_valid = 1'b0;
    chk("wrap count_B cnt16", {48'd0, count_B}, 64'd17);
    chk("wrap count_B cnt4", {60'd0, s_count_B}, 64'd1);
    chk("wrap B data", {32'd0, B}, 64'h110);

    // Mid-stream reset: nothing is delivered afterwards, counting restarts.
    select = 2'd3; in_valid = 1'b1; out_ready = 4'b0000;
    in_data = 32'hA5A5A5A5;
    step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst out_valid", {60'd0, out_valid}, 64'h0);
    #1 rst = 1'b0;
    step();
    chk("post_rst no delivery", {60'd0, out_valid}, 64'h0);
    in_valid = 1'b1; select = 2'd0; in_data = 32'h77;
    step();
    in_valid = 1'b0;
    chk("post_rst first accept", {count_A, count_D, A}, {16'd1, 16'd0, 32'h77});
    chk("post_rst out_valid", {60'd0, out_valid}, 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_4.md
Name: demux_4

Overview:
- Registered 1-to-4 distributor: the scatter counterpart of the 4:1 result mux.
- Accepts one 32-bit word per cycle on a valid/ready input, tagged with a 2-bit select. Delivers the word to exactly one of four output channels A/B/C/D.
- Each channel has a one-entry holding register with its own valid/ready handshake, so a stalled consumer blocks only its own channel.
- Sits between a producer (e.g. an ALU/write-back source) and up to four independent consumers.

Parameters:
- WIDTH, 32, data width of input and all outputs.
- CNT_W, 16, width of the per-channel accepted-word counters.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  producer has a word.
- in_ready  output  1  distributor can accept this cycle; combinational.
- in_data  input  WIDTH  word to route.
- select  input  2  destination: 00=A, 01=B, 10=C, 11=D.
- A, B, C, D  output  WIDTH each  channel data, registered.
- out_valid  output  4  per-channel valid; bit0=A … bit3=D.
- out_ready  input  4  per-channel consumer ready; bit0=A … bit3=D.
- count_A, count_B, count_C, count_D  output  CNT_W each  words accepted per channel since reset.

Behaviour:
- Reset (async assert, synchronous release behaviour on next clk edge): out_valid=4'b0000, A/B/C/D=0, all count_*=0. Reset mid-operation discards held words; no word is delivered after reset.
- Accept condition: acc = in_valid && in_ready.
- in_ready = !out_valid[select] || out_ready[select]. It depends only on the selected channel; other channels' state is ignored.
- in_ready is valid regardless of in_valid. select and in_data are don't-care when in_valid=0.
- On acc, at the next edge:
  - channel[select] data <= in_data
  - out_valid[select] <= 1
  - count[select] <= count[select]+1
- Latency: a word accepted in cycle N is visible on its channel with out_valid=1 in cycle N+1.
- Drain: channel k transfers when out_valid[k] && out_ready[k]. If it is not reloaded the same cycle, out_valid[k] <= 0 at the next edge. The data register holds its last value; it is not cleared.
- Simultaneous drain and load of the same channel:
  - out_valid stays 1 and data becomes the new word.
  - Full-throughput back-to-back streaming, one word per cycle per channel, with no bubble.
- Simultaneous drain on channel j and load on channel k≠j: both take effect independently.
- Channel full and consumer not ready: in_ready=0 for that select. The producer must hold in_valid, in_data and select stable until acceptance; the bench checks this as a protocol assertion.
- Channels are independent: at most one channel is loaded per cycle, and any number may drain per cycle.
- Counters increment on accept, not on drain, and wrap modulo 2^CNT_W with no saturation or flag.
- out_valid never deasserts without a completed transfer, except on reset.
- No combinational path from in_data to outputs. The only combinational path is select/out_ready/out_valid -> in_ready.

Decomposition:
- Shared constants file (included by mux_4 users and demux_4):
  - SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11
  - default WIDTH=32
- One natural sub-module, demux_slot:
  - one-entry holding register, valid bit and CNT_W counter
  - inputs: load, data_in, ready
  - outputs: valid, data, count
  - instantiated four times
- Top level: decode select into one-hot load, plus the in_ready mux.

Test Plan:
- Reset: assert rst with out_valid=4'b0101 held -> out_valid=0000, A..D=0, all counts=0 immediately (before next clk edge).
- Single route:
  - in_data=32'hDEADBEEF, select=10, in_valid=1 for 1 cycle, out_ready=0000 -> next cycle out_valid=0100, C=DEADBEEF, count_C=1, others 0.
  - In the following cycle with select=10, in_ready=0.
- Backpressure isolation:
  - channel C full, out_ready=0000, select=10 -> in_ready=0.
  - Switch select=00 -> in_ready=1. Word 32'h1 lands on A; C still holds DEADBEEF.
- Streaming:
  - out_ready=1111, select=11, 8 consecutive words 1..8 -> in_ready stays 1 throughout.
  - D shows 1..8 in consecutive cycles with out_valid[3] continuously 1, and count_D=8.
- Drain:
  - A holding a word, out_ready[0]=1 for one cycle, no new load -> out_valid[0]=0 next cycle, A data unchanged.
- Counter wrap (CNT_W=4 override): 17 accepts to channel B -> count_B=1.
- Mid-stream reset: rst pulsed during streaming -> all out_valid=0; the first post-reset accept yields count=1.
